// File: rtl/ssd1306_spi_stream.sv
// SSD1306-class OLED streamer: power sequence, init list, then continuous frames from an
// external framebuffer with runtime commands between frames. Optional macro: OLED_ADDR_RESYNC_EN.
module ssd1306_spi_stream #(
    parameter int unsigned STARTUP_WAIT = 10000000,
    parameter int unsigned SCLK_DIV     = 1,
    parameter int unsigned COLS         = 128,
    parameter int unsigned PAGES        = 8,
    parameter int unsigned ADDR_W       = $clog2(COLS*PAGES)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              io_sclk,
    output logic              io_sdin,
    output logic              io_cs,
    output logic              io_dc,
    output logic              io_reset,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_data,
    output logic              cmd_ready,
    output logic              init_done,
    output logic              frame_start,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        POWER, LOAD_INIT, SEND, CHECK, GAP, FETCH, LOAD_DATA, LOAD_RESYNC
    } state_t;

    typedef enum logic [1:0] {K_INIT, K_CMD, K_DATA, K_RESYNC} kind_t;

    localparam int unsigned       DIV_W     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [31:0]       WAIT_LAST = 32'(STARTUP_WAIT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*PAGES - 1);
    localparam logic [4:0]        INIT_LAST = 5'd22;

    state_t            state_q;
    kind_t             kind_q;
    logic [31:0]       pwr_cnt_q;
    logic [1:0]        pwr_phase_q;
    logic [4:0]        init_idx_q;
    logic [7:0]        shreg_q;
    logic [2:0]        bit_q;
    logic [DIV_W-1:0]  div_q;
    logic              half_q;
    logic              sclk_q, sdin_q, cs_q, dc_q, panel_rst_n_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic              cmd_ready_q, init_done_q, frame_start_q, frame_done_q;
`ifdef OLED_ADDR_RESYNC_EN
    logic [2:0]        rs_idx_q;
`endif

    logic       load_en;
    logic [7:0] load_byte;
    logic       load_dc;

    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:  return 8'hAE;
            5'd1:  return 8'h81;
            5'd2:  return 8'h7F;
            5'd3:  return 8'hA6;
            5'd4:  return 8'h20;
            5'd5:  return 8'h00;
            5'd6:  return 8'hC8;
            5'd7:  return 8'h40;
            5'd8:  return 8'hA1;
            5'd9:  return 8'hA8;
            5'd10: return 8'(PAGES*8 - 1);
            5'd11: return 8'hD3;
            5'd12: return 8'h00;
            5'd13: return 8'hD5;
            5'd14: return 8'h80;
            5'd15: return 8'hD9;
            5'd16: return 8'h22;
            5'd17: return 8'hDB;
            5'd18: return 8'h20;
            5'd19: return 8'h8D;
            5'd20: return 8'h14;
            5'd21: return 8'hA4;
            default: return 8'hAF;
        endcase
    endfunction

`ifdef OLED_ADDR_RESYNC_EN
    function automatic logic [7:0] resync_rom(input logic [2:0] idx);
        case (idx)
            3'd0: return 8'h21;
            3'd1: return 8'h00;
            3'd2: return 8'(COLS - 1);
            3'd3: return 8'h22;
            3'd4: return 8'h00;
            default: return 8'(PAGES - 1);
        endcase
    endfunction
`endif

    // Every byte start (init, command, resync, data) shares one load path into SEND.
    always_comb begin
        load_en   = 1'b0;
        load_byte = '0;
        load_dc   = 1'b0;
        case (state_q)
            LOAD_INIT: begin
                load_en   = 1'b1;
                load_byte = init_rom(init_idx_q);
            end
            GAP: begin
                if (cmd_valid) begin
                    load_en   = 1'b1;
                    load_byte = cmd_data;
                end
            end
            LOAD_DATA: begin
                load_en   = 1'b1;
                load_byte = fb_data;
                load_dc   = 1'b1;
            end
`ifdef OLED_ADDR_RESYNC_EN
            LOAD_RESYNC: begin
                load_en   = 1'b1;
                load_byte = resync_rom(rs_idx_q);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= POWER;
            kind_q        <= K_INIT;
            pwr_cnt_q     <= '0;
            pwr_phase_q   <= '0;
            init_idx_q    <= '0;
            shreg_q       <= '0;
            bit_q         <= '0;
            div_q         <= '0;
            half_q        <= 1'b0;
            sclk_q        <= 1'b1;
            sdin_q        <= 1'b0;
            cs_q          <= 1'b1;
            dc_q          <= 1'b1;
            panel_rst_n_q <= 1'b1;
            fb_addr_q     <= '0;
            cmd_ready_q   <= 1'b0;
            init_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef OLED_ADDR_RESYNC_EN
            rs_idx_q      <= '0;
`endif
        end else begin
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            cmd_ready_q   <= 1'b0;
            case (state_q)
                POWER: begin
                    if (pwr_cnt_q == WAIT_LAST) begin
                        pwr_cnt_q   <= '0;
                        pwr_phase_q <= pwr_phase_q + 2'd1;
                        case (pwr_phase_q)
                            2'd0:    panel_rst_n_q <= 1'b0;
                            2'd1:    panel_rst_n_q <= 1'b1;
                            default: begin
                                state_q <= LOAD_INIT;
                                cs_q    <= 1'b0;
                                dc_q    <= 1'b0;
                            end
                        endcase
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q + 32'd1;
                    end
                end
                SEND: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (!half_q) begin
                            sclk_q <= 1'b1;
                            half_q <= 1'b1;
                        end else if (bit_q == 3'd7) begin
                            state_q <= CHECK;
                            cs_q    <= 1'b1;
                        end else begin
                            sclk_q  <= 1'b0;
                            half_q  <= 1'b0;
                            sdin_q  <= shreg_q[6];
                            shreg_q <= {shreg_q[6:0], 1'b0};
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                CHECK: begin
                    case (kind_q)
                        K_INIT: begin
                            if (init_idx_q == INIT_LAST) begin
                                init_done_q <= 1'b1;
                                state_q     <= GAP;
                                cmd_ready_q <= 1'b1;
                            end else begin
                                init_idx_q <= init_idx_q + 5'd1;
                                state_q    <= LOAD_INIT;
                                cs_q       <= 1'b0;
                            end
                        end
                        K_DATA: begin
                            if (fb_addr_q == LAST_ADDR) begin
                                fb_addr_q    <= '0;
                                frame_done_q <= 1'b1;
                                state_q      <= GAP;
                                cmd_ready_q  <= 1'b1;
                            end else begin
                                fb_addr_q <= fb_addr_q + 1'b1;
                                state_q   <= FETCH;
                                cs_q      <= 1'b0;
                            end
                        end
`ifdef OLED_ADDR_RESYNC_EN
                        K_RESYNC: begin
                            cs_q <= 1'b0;
                            if (rs_idx_q == 3'd5) begin
                                rs_idx_q <= '0;
                                state_q  <= FETCH;
                            end else begin
                                rs_idx_q <= rs_idx_q + 3'd1;
                                state_q  <= LOAD_RESYNC;
                            end
                        end
`endif
                        default: begin
                            state_q     <= GAP;
                            cmd_ready_q <= 1'b1;
                        end
                    endcase
                end
                GAP: begin
                    if (cmd_valid) begin
                        kind_q <= K_CMD;
                    end else begin
                        fb_addr_q <= '0;
                        cs_q      <= 1'b0;
`ifdef OLED_ADDR_RESYNC_EN
                        rs_idx_q  <= '0;
                        state_q   <= LOAD_RESYNC;
`else
                        state_q   <= FETCH;
`endif
                    end
                end
                FETCH:       state_q <= LOAD_DATA;
                LOAD_INIT:   kind_q  <= K_INIT;
                LOAD_RESYNC: kind_q  <= K_RESYNC;
                LOAD_DATA: begin
                    kind_q        <= K_DATA;
                    frame_start_q <= (fb_addr_q == '0);
                end
                default: ;
            endcase
            if (load_en) begin
                shreg_q <= load_byte;
                sdin_q  <= load_byte[7];
                sclk_q  <= 1'b0;
                cs_q    <= 1'b0;
                dc_q    <= load_dc;
                bit_q   <= '0;
                div_q   <= '0;
                half_q  <= 1'b0;
                state_q <= SEND;
            end
        end
    end

    assign io_sclk     = sclk_q;
    assign io_sdin     = sdin_q;
    assign io_cs       = cs_q;
    assign io_dc       = dc_q;
    assign io_reset    = panel_rst_n_q;
    assign fb_addr     = fb_addr_q;
    assign cmd_ready   = cmd_ready_q;
    assign init_done   = init_done_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ssd1306_spi_stream.sv
// Scoreboard bench for ssd1306_spi_stream: expected {dc,byte} stream queued by stimulus,
// popped by an SPI monitor. Honors OLED_ADDR_RESYNC_EN.
module tb_ssd1306_spi_stream;

    localparam int unsigned SW  = 4;
    localparam int unsigned DIV = 3;
    localparam int unsigned C   = 4;
    localparam int unsigned P   = 2;

    localparam logic [7:0] INIT_TBL [0:22] = '{
        8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40, 8'hA1, 8'hA8, 8'h0F, 8'hD3,
        8'h00, 8'hD5, 8'h80, 8'hD9, 8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
    localparam logic [7:0] FRAME_TBL [0:7] = '{
        8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5E, 8'h5F, 8'h5C, 8'h5D};
    localparam logic [7:0] RESYNC_TBL [0:5] = '{8'h21, 8'h00, 8'h03, 8'h22, 8'h00, 8'h01};
`ifdef OLED_ADDR_RESYNC_EN
    localparam int FRAME_LEN = 14;
`else
    localparam int FRAME_LEN = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       io_sclk, io_sdin, io_cs, io_dc, io_reset;
    logic [2:0] fb_addr;
    logic [7:0] fb_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, init_done, frame_start, frame_done;

    always #5 clk = ~clk;

    ssd1306_spi_stream #(
        .STARTUP_WAIT(SW),
        .SCLK_DIV    (DIV),
        .COLS        (C),
        .PAGES       (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .io_sclk    (io_sclk),
        .io_sdin    (io_sdin),
        .io_cs      (io_cs),
        .io_dc      (io_dc),
        .io_reset   (io_reset),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .init_done  (init_done),
        .frame_start(frame_start),
        .frame_done (frame_done)
    );

    // Synchronous framebuffer model: one clock of read latency.
    always @(posedge clk) fb_data <= {5'b0, fb_addr} ^ 8'h5A;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_init();
        for (int i = 0; i < 23; i++) exp_q.push_back({1'b0, INIT_TBL[i]});
    endtask

    task automatic push_frame();
`ifdef OLED_ADDR_RESYNC_EN
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, RESYNC_TBL[i]});
`endif
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, FRAME_TBL[i]});
    endtask

    // ---------------- monitor ----------------
    logic       sclk_prev = 1'b1, cs_prev = 1'b1, fs_prev = 1'b0, fd_prev = 1'b0, id_prev = 1'b0;
    logic       cs_bad = 1'b0;
    logic [7:0] shifter = 8'h00;
    logic [8:0] last_byte = 9'h000;
    int         bitcnt = 0, low_run = 0, high_run = 0, byte_len = 0, cs_high_run = 0;
    int         bytes_seen = 0, fs_cnt = 0, fd_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            sclk_prev = 1'b1; cs_prev = 1'b1; fs_prev = 1'b0; fd_prev = 1'b0; id_prev = 1'b0;
            cs_bad = 1'b0; bitcnt = 0; byte_len = 0; cs_high_run = 0;
            bytes_seen = 0; fs_cnt = 0; fd_cnt = 0; last_byte = 9'h000;
        end else begin
            byte_len++;
            if (!io_sclk && sclk_prev) begin
                if (bitcnt != 0) check("sclk high half", high_run, DIV);
                else byte_len = 0;
                low_run = 1;
            end else if (io_sclk && !sclk_prev) begin
                check("sclk low half", low_run, DIV);
                high_run = 1;
                shifter = {shifter[6:0], io_sdin};
                if (io_cs) cs_bad = 1'b1;
                bitcnt++;
                if (bitcnt == 8) begin
                    bitcnt = 0;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected byte: got dc=%0b data=%0h expected nothing", io_dc, shifter);
                    end else begin
                        check("spi byte {cs_bad,dc,data}", {cs_bad, io_dc, shifter}, {1'b0, exp_q.pop_front()});
                    end
                    last_byte = {io_dc, shifter};
                    bytes_seen++;
                    cs_bad = 1'b0;
                end
            end else if (io_sclk) high_run++;
            else low_run++;

            if (io_cs && !cs_prev) check("byte length clks", byte_len, 16*DIV);
            if (io_cs) cs_high_run++;
            else if (cs_prev) begin
                if (bytes_seen >= 1 && bytes_seen < 23) check("cs high between init bytes", cs_high_run, 1);
                cs_high_run = 0;
            end

            if (init_done && !id_prev) begin
                check("init_done byte count", bytes_seen, 23);
                check("init_done last byte", last_byte, 9'h0AF);
            end
            if (frame_start) begin
                check("frame_start {prev,addr,dc,cs,sclk}", {fs_prev, fb_addr, io_dc, io_cs, io_sclk},
                      {1'b0, 3'd0, 1'b1, 1'b0, 1'b0});
                fs_cnt++;
            end
            if (frame_done) begin
                fd_cnt++;
                check("frame_done {prev,cmd_ready,last}", {fd_prev, cmd_ready, last_byte},
                      {1'b0, 1'b1, 9'h15D});
                check("frame start/done count", fs_cnt, fd_cnt);
            end
            if (cmd_ready) check("cmd_ready {cs,init_done}", {io_cs, init_done}, 2'b11);

            sclk_prev = io_sclk; cs_prev = io_cs; fs_prev = frame_start;
            fd_prev = frame_done; id_prev = init_done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_event(input int which, input int budget, input string name);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0:       seen = frame_start;
                1:       seen = frame_done;
                default: seen = cmd_ready;
            endcase
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout %s: waited %0d cycles, required event within %0d", name, n, budget);
        end
    endtask

    task automatic check_reset_values(input string name);
        check(name, {io_sclk, io_sdin, io_cs, io_dc, io_reset, fb_addr, cmd_ready, init_done, frame_start, frame_done},
              {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 4'b0000});
    endtask

    // Releases reset on a falling edge; edge k is the k-th rising clk afterwards.
    task automatic power_check();
        int fall_at = -1, rise_at = -1, cs_at = -1, sclk_at = -1;
        bit cs_ok = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (fall_at < 0 && !io_reset) fall_at = k;
            if (fall_at >= 0 && rise_at < 0 && io_reset) rise_at = k;
            if (rise_at < 0 && !io_cs) cs_ok = 1'b0;
            if (cs_at < 0 && !io_cs) cs_at = k;
            if (sclk_at < 0 && !io_sclk) sclk_at = k;
        end
        check("io_reset fall edge", fall_at, SW);
        check("io_reset rise edge", rise_at, 2*SW);
        check("io_cs first fall edge", cs_at, 3*SW);
        check("io_sclk first fall edge", sclk_at, 3*SW + 1);
        check("io_cs high during power", cs_ok, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values("reset state");
        push_init();
        push_frame();
        power_check();

        wait_event(0, 2500, "frame_start 1");
        cmd_data  = 8'hA7;
        cmd_valid = 1'b1;
        exp_q.push_back({1'b0, 8'hA7});
        push_frame();
        wait_event(2, 1200, "cmd_ready A7");
        check("A7 accepted with frame_done", frame_done, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        wait_event(0, 1200, "frame_start 2");
        cmd_data  = 8'hA6;
        cmd_valid = 1'b1;
        exp_q.push_back({1'b0, 8'hA6});
        exp_q.push_back({1'b0, 8'hA7});
        push_frame();
        wait_event(2, 1200, "cmd_ready A6");
        check("A6 accepted with frame_done", frame_done, 1);
        @(posedge clk); #1;
        cmd_data = 8'hA7;
        wait_event(2, 200, "cmd_ready second queued");
        check("second cmd frame_done", frame_done, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        wait_event(0, 1200, "frame_start 3");
        push_frame();
        wait_event(1, 1200, "frame_done 3");
        check("queue depth after frame 3", exp_q.size(), FRAME_LEN);

        wait_event(0, 1200, "frame_start 4");
        repeat (20) @(negedge clk);
        check("cs low mid-byte", io_cs, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_values("async reset mid-byte");
        exp_q.delete();
        push_init();
        push_frame();
        repeat (2) @(negedge clk);
        power_check();

        wait_event(1, 3500, "frame_done after reset");
        repeat (2) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
